// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads two consecutive bytes at pc, assembles a 16-bit instruction
// and offers it to the decoder over a valid/ready handshake.
module instr_fetch #(
  parameter int unsigned   AW       = 5,
  parameter int unsigned   DW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            bus_busy_i,
  input  logic [DW-1:0]   mem_data_i,
  output logic [AW-1:0]   mem_addr_o,
  output logic            mem_rd_o,
  input  logic            pc_load_i,
  input  logic [AW-1:0]   pc_load_addr_i,
  output logic [2*DW-1:0] ir_o,
  output logic            ir_valid_o,
  input  logic            ir_ready_i,
  output logic [AW-1:0]   pc_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRdHi  = 2'd1;
  localparam logic [1:0] StRdLo  = 2'd2;
  localparam logic [1:0] StValid = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [2*DW-1:0] ir_q, ir_d;
  logic [AW-1:0]   pc_inc;

  // Wraps modulo 2^AW, so an instruction may straddle the top of memory.
  assign pc_inc = pc_q + AW'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    if (pc_load_i) begin
      // Jump wins over everything; any partially fetched byte is abandoned.
      pc_d    = pc_load_addr_i;
      state_d = en_i ? StRdHi : StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (en_i) state_d = StRdHi;
        end
        StRdHi: begin
          if (!bus_busy_i) begin
            ir_d[2*DW-1:DW] = mem_data_i;
            pc_d            = pc_inc;
            state_d         = StRdLo;
          end
        end
        StRdLo: begin
          if (!bus_busy_i) begin
            ir_d[DW-1:0] = mem_data_i;
            pc_d         = pc_inc;
            state_d      = StValid;
          end
        end
        StValid: begin
          if (ir_ready_i) state_d = en_i ? StRdHi : StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign mem_addr_o = pc_q;
  assign pc_o       = pc_q;
  assign ir_o       = ir_q;
  assign ir_valid_o = (state_q == StValid);
  // The only combinational input-to-output path: yield the bus to the execute stage.
  assign mem_rd_o   = ((state_q == StRdHi) || (state_q == StRdLo)) && !bus_busy_i;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a byte-counting behavioural model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, bus_busy, pc_load, ir_ready;
  logic [4:0]  pc_load_addr;
  logic [7:0]  mem_data;
  logic [4:0]  mem_addr, pc;
  logic        mem_rd, ir_valid;
  logic [15:0] ir;
  logic [7:0]  mem [32];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: whether a fetch/hold is in progress, how many bytes of it are in, pc and ir.
  bit          m_active;
  int          m_nbytes;
  logic [4:0]  m_pc;
  logic [15:0] m_ir;

  instr_fetch #(.AW(5), .DW(8), .RESET_PC(5'd0)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .en_i           (en),
    .bus_busy_i     (bus_busy),
    .mem_data_i     (mem_data),
    .mem_addr_o     (mem_addr),
    .mem_rd_o       (mem_rd),
    .pc_load_i      (pc_load),
    .pc_load_addr_i (pc_load_addr),
    .ir_o           (ir),
    .ir_valid_o     (ir_valid),
    .ir_ready_i     (ir_ready),
    .pc_o           (pc)
  );

  always #5 clk = ~clk;
  assign mem_data = mem[mem_addr];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_nbytes = 0;
    m_pc     = 5'd0;
    m_ir     = 16'h0;
  endtask

  task automatic model_edge();
    if (pc_load) begin
      m_pc     = pc_load_addr;
      m_nbytes = 0;
      m_active = en;
    end else if (!m_active) begin
      if (en) begin
        m_active = 1'b1;
        m_nbytes = 0;
      end
    end else if (m_nbytes < 2) begin
      if (!bus_busy) begin
        if (m_nbytes == 0) m_ir[15:8] = mem[m_pc];
        else               m_ir[7:0]  = mem[m_pc];
        m_pc = m_pc + 5'd1;
        m_nbytes++;
      end
    end else if (ir_ready) begin
      m_active = en;
      m_nbytes = 0;
    end
  endtask

  task automatic compare();
    logic exp_valid, exp_rd;
    exp_valid = m_active && (m_nbytes == 2);
    exp_rd    = m_active && (m_nbytes < 2) && !bus_busy;
    chk("pc", {11'b0, pc}, {11'b0, m_pc});
    chk("mem_addr", {11'b0, mem_addr}, {11'b0, m_pc});
    chk("ir_valid", {15'b0, ir_valid}, {15'b0, exp_valid});
    chk("mem_rd", {15'b0, mem_rd}, {15'b0, exp_rd});
    if (exp_valid) chk("ir", ir, m_ir);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    compare();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA3; mem[1] = 8'h1F; mem[2] = 8'h55; mem[3] = 8'hAA;
    mem[5] = 8'h3C; mem[6] = 8'hC3; mem[30] = 8'h42; mem[31] = 8'h07;
    rst_n = 1'b0; en = 1'b0; bus_busy = 1'b0; ir_ready = 1'b0;
    pc_load = 1'b0; pc_load_addr = 5'd0;
    model_reset();

    #3;
    chk("rst_pc", {11'b0, pc}, 16'd0);
    chk("rst_mem_addr", {11'b0, mem_addr}, 16'd0);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_ir_valid", {15'b0, ir_valid}, 16'd0);
    chk("rst_mem_rd", {15'b0, mem_rd}, 16'd0);
    #9 rst_n = 1'b1;

    // Basic fetch of A3,1F then hold in VALID for 5 cycles.
    en = 1'b1;
    tick();
    chk("t1_rd_hi", {15'b0, mem_rd}, 16'd1);
    chk("t1_addr0", {11'b0, mem_addr}, 16'd0);
    tick();
    chk("t1_rd_lo", {15'b0, mem_rd}, 16'd1);
    chk("t1_addr1", {11'b0, mem_addr}, 16'd1);
    tick();
    chk("t1_valid", {15'b0, ir_valid}, 16'd1);
    chk("t1_ir", ir, 16'hA31F);
    chk("t1_pc", {11'b0, pc}, 16'd2);
    repeat (5) begin
      tick();
      chk("t2_valid", {15'b0, ir_valid}, 16'd1);
      chk("t2_ir", ir, 16'hA31F);
      chk("t2_mem_rd", {15'b0, mem_rd}, 16'd0);
      chk("t2_pc", {11'b0, pc}, 16'd2);
    end

    // Bus stolen for 3 cycles during the low byte.
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    tick();
    bus_busy = 1'b1;
    repeat (3) begin
      #1;
      chk("t3_mem_rd", {15'b0, mem_rd}, 16'd0);
      tick();
      chk("t3_pc", {11'b0, pc}, 16'd3);
      chk("t3_no_valid", {15'b0, ir_valid}, 16'd0);
    end
    bus_busy = 1'b0;
    tick();
    chk("t3_valid", {15'b0, ir_valid}, 16'd1);
    chk("t3_ir", ir, 16'h55AA);

    // Jump to 30 together with transfer; instruction straddles the wrap.
    pc_load = 1'b1; pc_load_addr = 5'd30; ir_ready = 1'b1;
    tick();
    chk("t4_pc30", {11'b0, pc}, 16'd30);
    chk("t4_no_valid", {15'b0, ir_valid}, 16'd0);
    pc_load = 1'b0; ir_ready = 1'b0;
    tick();
    tick();
    chk("t4_ir", ir, 16'h4207);
    chk("t4_wrap", {11'b0, pc}, 16'd0);

    // Jump while in RD_LO discards the partial instruction.
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    tick();
    pc_load = 1'b1; pc_load_addr = 5'd5;
    tick();
    pc_load = 1'b0;
    chk("t5_no_valid", {15'b0, ir_valid}, 16'd0);
    chk("t5_addr5", {11'b0, mem_addr}, 16'd5);
    chk("t5_rd5", {15'b0, mem_rd}, 16'd1);
    tick();
    chk("t5_addr6", {11'b0, mem_addr}, 16'd6);
    chk("t5_no_valid2", {15'b0, ir_valid}, 16'd0);
    tick();
    chk("t5_ir", ir, 16'h3CC3);
    chk("t5_pc", {11'b0, pc}, 16'd7);

    // Asynchronous reset between edges while in RD_LO.
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_valid", {15'b0, ir_valid}, 16'd0);
    chk("t6_mem_rd", {15'b0, mem_rd}, 16'd0);
    chk("t6_pc", {11'b0, pc}, 16'd0);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("t6_idle_rd", {15'b0, mem_rd}, 16'd0);
    end

    // Randomized traffic.
    repeat (4000) begin
      en           = ($urandom_range(0, 9) != 0);
      bus_busy     = ($urandom_range(0, 9) < 3);
      ir_ready     = $urandom_range(0, 1) == 1;
      pc_load      = ($urandom_range(0, 19) == 0);
      pc_load_addr = 5'($urandom);
      if ($urandom_range(0, 7) == 0) mem[$urandom_range(0, 31)] = 8'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
